rtc_time_pixel_gen: RTL

Pixel generator that sits directly downstream of the 640x480 VGA sync generator. It consumes pixel_X, pixel_Y, p_tick and the active-low syncs, and renders the RTC time as "HH:MM:SS" in an 8x16 font scaled x4. It outputs 8-bit RGB with pipeline-aligned syncs to the VGA connector. When the user is editing the time, the selected field blinks.

---
 rtl/rtc_time_pixel_gen.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_time_pixel_gen.sv
// rtc_time_pixel_gen
// Pixel generator placed after the 640x480 VGA sync generator. Draws the
// latched RTC time as "HH:MM:SS" using an 8x16 font scaled x4 inside a
// 256x64 text box, and blinks the field currently being edited.
// The pipeline has three stages, and each stage advances once per pixel
// enable (the rising edge of p_tick):
//   1) decode the position and register the syncs
//   2) select the glyph and read the font ROM
//   3) produce the colour
//
// Ports:
//   CLK              system clock (100 MHz)
//   RESET            asynchronous reset, active low
//   p_tick           25 MHz pixel tick level from the sync generator
//   pixel_X/pixel_Y  current scan position from the sync generator
//   sincro_*_in      active-low hsync/vsync from the sync generator
//   hora/min/seg_bcd time to display, BCD {tens,units}
//   edit_field       0 none, 1 hours, 2 minutes, 3 seconds (blinks)
//   rgb              RRRGGGBB pixel colour
//   sincro_horiz/_vert syncs delayed to line up with rgb
//
// Build option: define COLON_BLINK_EN to blink the colons
// (30 frames on, 30 frames off).
module rtc_time_pixel_gen #(
  parameter logic [9:0] TX0          = 10'd192,
  parameter logic [9:0] TY0          = 10'd208,
  parameter logic [7:0] FG_COLOR     = 8'h1C,
  parameter logic [7:0] BG_COLOR     = 8'h00,
  parameter int         BLINK_FRAMES = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       p_tick,
  input  logic [9:0] pixel_X,
  input  logic [9:0] pixel_Y,
  input  logic       sincro_horiz_in,
  input  logic       sincro_vert_in,
  input  logic [7:0] hora_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] seg_bcd,
  input  logic [1:0] edit_field,
  output logic [7:0] rgb,
  output logic       sincro_horiz,
  output logic       sincro_vert
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);

  // Glyphs are drawn as seven-segment shapes. seg = {a,b,c,d,e,f,g}.
  // Code 10 is the colon; codes 11-15 are blank.
  function automatic logic [7:0] font_rom(input logic [3:0] code, input logic [3:0] row);
    logic [6:0] seg;
    logic [7:0] bits;
    seg  = 7'b0;
    bits = 8'h00;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (code == 4'd10) begin
      if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11)
        bits = 8'h18;
    end else begin
      case (row)
        4'd1:                         bits = seg[6] ? 8'h3C : 8'h00;
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6: bits = (seg[1] ? 8'h40 : 8'h00) | (seg[5] ? 8'h02 : 8'h00);
        4'd7:                         bits = seg[0] ? 8'h3C : 8'h00;
        4'd8, 4'd9, 4'd10, 4'd11,
        4'd12, 4'd13:                 bits = (seg[2] ? 8'h40 : 8'h00) | (seg[4] ? 8'h02 : 8'h00);
        4'd14:                        bits = seg[3] ? 8'h3C : 8'h00;
        default:                      bits = 8'h00;
      endcase
    end
    return bits;
  endfunction

  // Pixel enable
  logic p_tick_q;
  logic pe;
  assign pe = p_tick & ~p_tick_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) p_tick_q <= 1'b0;
    else        p_tick_q <= p_tick;
  end

  // Stage 1: position decode
  logic [5:0] x_cell;
  logic [3:0] y_cell;
  logic       video_on_c;
  logic       in_box_c;

  always_comb begin
    x_cell     = 6'((pixel_X - TX0) >> 2);
    y_cell     = 4'((pixel_Y - TY0) >> 2);
    video_on_c = (pixel_X < 10'd640) && (pixel_Y < 10'd480);
    in_box_c   = ({1'b0, pixel_X} >= {1'b0, TX0}) &&
                 ({1'b0, pixel_X} <  {1'b0, TX0} + 11'd256) &&
                 ({1'b0, pixel_Y} >= {1'b0, TY0}) &&
                 ({1'b0, pixel_Y} <  {1'b0, TY0} + 11'd64);
  end

  logic       s1_video_on, s1_in_box, s1_hs, s1_vs;
  logic [2:0] s1_idx, s1_col;
  logic [3:0] s1_row;
  logic [1:0] s1_edit;

  // The sync stages reset to the inactive level (1). This keeps the
  // outputs from glitching low while the pipeline refills.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1_video_on <= 1'b0;
      s1_in_box   <= 1'b0;
      s1_idx      <= 3'd0;
      s1_col      <= 3'd0;
      s1_row      <= 4'd0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_edit     <= 2'd0;
    end else if (pe) begin
      s1_video_on <= video_on_c;
      s1_in_box   <= in_box_c;
      s1_idx      <= x_cell[5:3];
      s1_col      <= x_cell[2:0];
      s1_row      <= y_cell;
      s1_hs       <= sincro_horiz_in;
      s1_vs       <= sincro_vert_in;
      s1_edit     <= edit_field;
    end
  end

  // s1_vs holds vsync from the previous pixel, so this detects the start of a frame.
  logic vs_fall;
  assign vs_fall = pe & s1_vs & ~sincro_vert_in;

  // Time latch and blink counter
  logic [7:0]    t_hora, t_min, t_seg;
  logic [1:0]    edit_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          colon_phase;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      t_hora <= 8'h00;
      t_min  <= 8'h00;
      t_seg  <= 8'h00;
    end else if (vs_fall) begin
      t_hora <= hora_bcd;
      t_min  <= min_bcd;
      t_seg  <= seg_bcd;
    end
  end

  // Changing the selected field restarts the blink, so the new field shows at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      edit_q      <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      edit_q <= edit_field;
      if (edit_field != edit_q) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (vs_fall) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

`ifdef COLON_BLINK_EN
  logic [4:0] colon_cnt;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      colon_cnt   <= 5'd0;
      colon_phase <= 1'b0;
    end else if (vs_fall) begin
      if (colon_cnt == 5'd29) begin
        colon_cnt   <= 5'd0;
        colon_phase <= ~colon_phase;
      end else begin
        colon_cnt <= colon_cnt + 5'd1;
      end
    end
  end
`else
  assign colon_phase = 1'b0;
`endif

  // Stage 2: glyph select and font read
  logic [3:0] nib, code_c;
  logic [1:0] fld;
  logic       is_colon, hide_c;

  always_comb begin
    nib      = 4'd0;
    fld      = 2'd0;
    is_colon = 1'b0;
    case (s1_idx)
      3'd0:    begin nib = t_hora[7:4]; fld = 2'd1; end
      3'd1:    begin nib = t_hora[3:0]; fld = 2'd1; end
      3'd3:    begin nib = t_min[7:4];  fld = 2'd2; end
      3'd4:    begin nib = t_min[3:0];  fld = 2'd2; end
      3'd6:    begin nib = t_seg[7:4];  fld = 2'd3; end
      3'd7:    begin nib = t_seg[3:0];  fld = 2'd3; end
      default: is_colon = 1'b1;
    endcase
    code_c = is_colon ? 4'd10 : ((nib > 4'd9) ? 4'd15 : nib);
    hide_c = (blink_phase && !is_colon && (s1_edit != 2'd0) && (s1_edit == fld)) ||
             (is_colon && colon_phase);
  end

  logic [7:0] s2_rom;
  logic [2:0] s2_col;
  logic       s2_video_on, s2_in_box, s2_hide, s2_hs, s2_vs;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s2_rom      <= 8'h00;
      s2_col      <= 3'd0;
      s2_video_on <= 1'b0;
      s2_in_box   <= 1'b0;
      s2_hide     <= 1'b0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
    end else if (pe) begin
      s2_rom      <= font_rom(code_c, s1_row);
      s2_col      <= s1_col;
      s2_video_on <= s1_video_on;
      s2_in_box   <= s1_in_box;
      s2_hide     <= hide_c;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
    end
  end

  // Stage 3: colour. Column 0 is the MSB of the font row.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rgb          <= 8'h00;
      sincro_horiz <= 1'b1;
      sincro_vert  <= 1'b1;
    end else if (pe) begin
      if (!s2_video_on)
        rgb <= 8'h00;
      else if (s2_in_box && s2_rom[3'd7 - s2_col] && !s2_hide)
        rgb <= FG_COLOR;
      else
        rgb <= BG_COLOR;
      sincro_horiz <= s2_hs;
      sincro_vert  <= s2_vs;
    end
  end

endmodule
